// File: rtl/cpu_pkg.sv
// Shared opcode values, instruction field positions and decoder FSM state encodings.
package cpu_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_ADD  = 3'b001,
    OP_ADDI = 3'b010,
    OP_SUB  = 3'b011,
    OP_SUBI = 3'b100,
    OP_MUL  = 3'b101,
    OP_MOVI = 3'b110,
    OP_HALT = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_EXEC   = 2'b01,
    ST_WB     = 2'b10,
    ST_HALTED = 2'b11
  } state_e;

  localparam int OPC_LSB  = 13;
  localparam int RD_LSB   = 10;
  localparam int RS1_LSB  = 7;
  localparam int RS2_LSB  = 4;
  localparam int REG_AW   = 3;
  localparam int DATA_W   = 16;

endpackage

// File: rtl/regfile.sv
// 8x16 register file: two async read ports, one async debug read port, one sync write port.
// R0 is hardwired to zero: writes to it are dropped.
module regfile
  import cpu_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REG_AW-1:0]        ra1,
  input  logic [REG_AW-1:0]        ra2,
  input  logic [REG_AW-1:0]        dbg_ra,
  input  logic                     we,
  input  logic [REG_AW-1:0]        wa,
  input  logic signed [DATA_W-1:0] wd,
  output logic signed [DATA_W-1:0] rd1,
  output logic signed [DATA_W-1:0] rd2,
  output logic signed [DATA_W-1:0] dbg_rd
);

  logic signed [DATA_W-1:0] regs_q [8];
  logic signed [DATA_W-1:0] regs_d [8];

  always_comb begin
    regs_d = regs_q;
    if (we && (wa != '0)) regs_d[wa] = wd;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rd1    = (ra1    == '0) ? '0 : regs_q[ra1];
  assign rd2    = (ra2    == '0) ? '0 : regs_q[ra2];
  assign dbg_rd = (dbg_ra == '0) ? '0 : regs_q[dbg_ra];

endmodule

// File: rtl/decode_stage.sv
// Multi-cycle decode stage: IDLE -> EXEC -> WB per ALU instruction, NOP retires at accept, HALT parks.
// Optional retired-instruction counter enabled by defining DECODE_RETIRE_CNT_EN.
module decode_stage
  import cpu_pkg::*;
#(
  parameter int IMM_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [15:0]        instr,
  output logic               instr_ready,
  output logic [2:0]         alu_opcode,
  output logic signed [15:0] alu_a,
  output logic signed [15:0] alu_b,
  output logic signed [15:0] alu_imm,
  input  logic signed [15:0] alu_result,
  output logic               halted,
  input  logic [2:0]         dbg_raddr,
  output logic [15:0]        dbg_rdata
`ifdef DECODE_RETIRE_CNT_EN
  ,
  output logic [15:0]        retire_cnt
`endif
);

  function automatic logic signed [15:0] sext(input logic [IMM_W-1:0] v);
    logic signed [IMM_W-1:0] s;
    s = v;
    return 16'(s);
  endfunction

  state_e      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic        halted_q, halted_d;
  logic        accept;
  opcode_e     opc_in, opc_q;
  logic signed [15:0] rs1_data, rs2_data, dbg_data;

  assign accept      = instr_valid && (state_q == ST_IDLE);
  assign opc_in      = opcode_e'(instr[OPC_LSB +: 3]);
  assign opc_q       = opcode_e'(instr_q[OPC_LSB +: 3]);
  assign instr_ready = (state_q == ST_IDLE);
  assign halted      = halted_q;
  assign dbg_rdata   = dbg_data;

  regfile u_regfile (
    .clk    (clk),
    .rst    (rst),
    .ra1    (instr_q[RS1_LSB +: REG_AW]),
    .ra2    (instr_q[RS2_LSB +: REG_AW]),
    .dbg_ra (dbg_raddr),
    .we     (state_q == ST_WB),
    .wa     (instr_q[RD_LSB +: REG_AW]),
    .wd     (alu_result),
    .rd1    (rs1_data),
    .rd2    (rs2_data),
    .dbg_rd (dbg_data)
  );

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    halted_d = halted_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          instr_d = instr;
          case (opc_in)
            OP_NOP:  state_d = ST_IDLE;
            OP_HALT: begin
              state_d  = ST_HALTED;
              halted_d = 1'b1;
            end
            default: state_d = ST_EXEC;
          endcase
        end
      end
      ST_EXEC:   state_d = ST_WB;
      ST_WB:     state_d = ST_IDLE;
      default:   state_d = ST_HALTED;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      instr_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      halted_q <= halted_d;
    end
  end

  // ALU operands are only live in EXEC; MOVI is issued to the ALU as ADDI from zero.
  always_comb begin
    alu_opcode = '0;
    alu_a      = '0;
    alu_b      = '0;
    alu_imm    = '0;
    if (state_q == ST_EXEC) begin
      alu_b   = rs2_data;
      alu_imm = sext(instr_q[IMM_W-1:0]);
      if (opc_q == OP_MOVI) begin
        alu_opcode = OP_ADDI;
      end else begin
        alu_opcode = opc_q;
        alu_a      = rs1_data;
      end
    end
  end

`ifdef DECODE_RETIRE_CNT_EN
  logic [15:0] retire_cnt_q, retire_cnt_d;

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if ((accept && (opc_in == OP_NOP || opc_in == OP_HALT)) || (state_q == ST_WB))
      retire_cnt_d = retire_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) retire_cnt_q <= '0;
    else      retire_cnt_q <= retire_cnt_d;
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with a small registered ALU model closing the loop.
module tb_decode_stage;

  logic               clk = 1'b0;
  logic               rst;
  logic               instr_valid;
  logic [15:0]        instr;
  logic               instr_ready;
  logic [2:0]         alu_opcode;
  logic signed [15:0] alu_a, alu_b, alu_imm;
  logic signed [15:0] alu_result;
  logic               halted;
  logic [2:0]         dbg_raddr;
  logic [15:0]        dbg_rdata;
`ifdef DECODE_RETIRE_CNT_EN
  logic [15:0]        retire_cnt;
`endif

  int total = 0;
  int fails = 0;

  decode_stage #(.IMM_W(7)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .alu_opcode  (alu_opcode),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_imm     (alu_imm),
    .alu_result  (alu_result),
    .halted      (halted),
    .dbg_raddr   (dbg_raddr),
    .dbg_rdata   (dbg_rdata)
`ifdef DECODE_RETIRE_CNT_EN
    ,
    .retire_cnt  (retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Registered ALU: result is presented the cycle after EXEC.
  always @(posedge clk) begin
    case (alu_opcode)
      3'b001:  alu_result <= alu_a + alu_b;
      3'b010:  alu_result <= alu_a + alu_imm;
      3'b011:  alu_result <= alu_a - alu_b;
      3'b100:  alu_result <= alu_a - alu_imm;
      3'b101:  alu_result <= alu_a * alu_imm;
      default: alu_result <= 16'sd0;
    endcase
  end

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [6:0] lo);
    return {op, rd, rs1, lo};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd_reg(input logic [2:0] r, input string tag, input logic [15:0] exp);
    dbg_raddr = r;
    #1;
    chk(tag, dbg_rdata, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one ALU instruction and walk it through EXEC and WB back to IDLE.
  task automatic run_alu(input logic [15:0] w);
    instr_valid = 1'b1;
    instr       = w;
    tick();
    instr_valid = 1'b0;
    instr       = 16'h0000;
    tick();
    tick();
  endtask

  task automatic do_reset;
    rst = 1'b0;
    #3;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    dbg_raddr   = 3'd0;
    #2;
    do_reset();

    chk("reset_ready", {15'b0, instr_ready}, 16'h0001);
    chk("reset_halted", {15'b0, halted}, 16'h0000);
    chk("reset_alu_op", {13'b0, alu_opcode}, 16'h0000);
    rd_reg(3'd1, "reset_r1", 16'h0000);

    // MOVI r1,#5 with per-cycle checks
    instr_valid = 1'b1;
    instr       = enc(3'b110, 3'd1, 3'd0, 7'd5);
    tick();
    instr_valid = 1'b0;
    chk("movi_exec_op", {13'b0, alu_opcode}, 16'h0002);
    chk("movi_exec_a", alu_a, 16'h0000);
    chk("movi_exec_imm", alu_imm, 16'h0005);
    chk("movi_exec_ready", {15'b0, instr_ready}, 16'h0000);
    tick();
    chk("movi_wb_ready", {15'b0, instr_ready}, 16'h0000);
    chk("movi_wb_op", {13'b0, alu_opcode}, 16'h0000);
    tick();
    chk("movi_c3_ready", {15'b0, instr_ready}, 16'h0001);
    rd_reg(3'd1, "movi_r1", 16'h0005);

    // R2=-3, ADD and SUB
    run_alu(enc(3'b110, 3'd2, 3'd0, 7'h7D));
    rd_reg(3'd2, "movi_r2_neg3", 16'hFFFD);
    instr_valid = 1'b1;
    instr       = enc(3'b001, 3'd3, 3'd1, {3'd2, 4'd0});
    tick();
    instr_valid = 1'b0;
    chk("add_exec_a", alu_a, 16'h0005);
    chk("add_exec_b", alu_b, 16'hFFFD);
    chk("add_exec_op", {13'b0, alu_opcode}, 16'h0001);
    tick();
    tick();
    rd_reg(3'd3, "add_r3", 16'h0002);
    run_alu(enc(3'b011, 3'd4, 3'd2, {3'd1, 4'd0}));
    rd_reg(3'd4, "sub_r4", 16'hFFF8);

    // Sign extension, MUL and 16-bit wrap
    instr_valid = 1'b1;
    instr       = enc(3'b110, 3'd1, 3'd0, 7'h40);
    tick();
    instr_valid = 1'b0;
    chk("movi_neg64_imm", alu_imm, 16'hFFC0);
    tick();
    tick();
    rd_reg(3'd1, "movi_r1_neg64", 16'hFFC0);
    run_alu(enc(3'b101, 3'd2, 3'd1, 7'h40));
    rd_reg(3'd2, "mul_r2", 16'h1000);
    run_alu(enc(3'b101, 3'd3, 3'd2, 7'd8));
    rd_reg(3'd3, "mul_r3_8000", 16'h8000);
    run_alu(enc(3'b100, 3'd3, 3'd3, 7'd1));
    rd_reg(3'd3, "subi_r3_7fff", 16'h7FFF);
    run_alu(enc(3'b010, 3'd4, 3'd3, 7'd1));
    rd_reg(3'd4, "addi_wrap_r4", 16'h8000);

    // R0 hardwired, NOP
    run_alu(enc(3'b010, 3'd0, 3'd0, 7'd7));
    rd_reg(3'd0, "addi_r0", 16'h0000);
    instr_valid = 1'b1;
    instr       = 16'h0000;
    tick();
    instr_valid = 1'b0;
    chk("nop_ready", {15'b0, instr_ready}, 16'h0001);
    rd_reg(3'd4, "nop_r4", 16'h8000);

    // HALT then instr_valid held high
    instr_valid = 1'b1;
    instr       = enc(3'b111, 3'd0, 3'd0, 7'd0);
    tick();
    instr = enc(3'b010, 3'd1, 3'd0, 7'd1);
    for (int i = 0; i < 10; i++) tick();
    chk("halt_halted", {15'b0, halted}, 16'h0001);
    chk("halt_ready", {15'b0, instr_ready}, 16'h0000);
    chk("halt_alu_op", {13'b0, alu_opcode}, 16'h0000);
    rd_reg(3'd1, "halt_r1", 16'hFFC0);
    instr_valid = 1'b0;
    do_reset();
    chk("halt_rst_halted", {15'b0, halted}, 16'h0000);
    chk("halt_rst_ready", {15'b0, instr_ready}, 16'h0001);
    rd_reg(3'd1, "halt_rst_r1", 16'h0000);

    // Reset during WB of ADD r5
    run_alu(enc(3'b110, 3'd1, 3'd0, 7'd5));
    run_alu(enc(3'b110, 3'd2, 3'd0, 7'd3));
    instr_valid = 1'b1;
    instr       = enc(3'b001, 3'd5, 3'd1, {3'd2, 4'd0});
    tick();
    instr_valid = 1'b0;
    tick();
    rst = 1'b0;
    #2;
    rd_reg(3'd5, "wb_rst_r5_async", 16'h0000);
    tick();
    rst = 1'b1;
    tick();
    rd_reg(3'd5, "wb_rst_r5", 16'h0000);
    chk("wb_rst_ready", {15'b0, instr_ready}, 16'h0001);

`ifdef DECODE_RETIRE_CNT_EN
    do_reset();
    chk("cnt_reset", retire_cnt, 16'h0000);
    instr_valid = 1'b1;
    instr       = 16'h0000;
    tick();
    tick();
    instr_valid = 1'b0;
    run_alu(enc(3'b110, 3'd1, 3'd0, 7'd1));
    instr_valid = 1'b1;
    instr       = enc(3'b111, 3'd0, 3'd0, 7'd0);
    tick();
    instr_valid = 1'b0;
    tick();
    chk("retire_cnt_4", retire_cnt, 16'h0004);
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter IMM_W, default 7, meaning the immediate field width in bits, which is sign-extended to 16.
REQ-002 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset; asynchronous, active-low.
REQ-004 SHALL have port instr_valid, input, 1 bit: upstream instruction word present.
REQ-005 SHALL have port instr, input, 16 bits: [15:13] opcode, [12:10] rd, [9:7] rs1, [6:4] rs2, [IMM_W-1:0] imm.
REQ-006 SHALL have port instr_ready, output, 1 bit: decoder accepts instr this cycle.
REQ-007 SHALL have port alu_opcode, output, 3 bits: operation code to the ALU.
REQ-008 SHALL have ports alu_a and alu_b, output, 16 bits signed: ALU register operands.
REQ-009 SHALL have port alu_imm, output, 16 bits signed: sign-extended immediate.
REQ-010 SHALL have port alu_result, input, 16 bits signed: registered ALU result, valid one cycle after EXEC.
REQ-011 SHALL have port halted, output, 1 bit: HALT retired.
REQ-012 SHALL have ports dbg_raddr, input, 3 bits, and dbg_rdata, output, 16 bits: asynchronous debug register read.

Function
REQ-013 SHALL implement an FSM with states IDLE, EXEC, WB and HALTED.
REQ-014 SHALL assert instr_ready only in IDLE; acceptance = instr_valid & instr_ready, latching instr.
REQ-015 SHALL, on accepting opcode 001–101 (ADD, ADDI, SUB, SUBI, MUL) or 110 (MOVI), transition IDLE->EXEC.
REQ-016 SHALL, on accepting opcode 000 (NOP), remain in IDLE and retire it in that cycle.
REQ-017 SHALL, on accepting opcode 111 (HALT), transition to HALTED; HALTED holds instr_ready=0 and halted=1 until reset.
REQ-018 SHALL, in EXEC, drive alu_a=R[rs1], alu_b=R[rs2], alu_imm=sext(imm) and alu_opcode=latched opcode; for MOVI it SHALL drive alu_opcode=010 with alu_a=0.
REQ-019 SHALL drive alu_opcode=000, alu_a=0, alu_b=0 and alu_imm=0 in every state other than EXEC.
REQ-020 SHALL transition EXEC->WB unconditionally and WB->IDLE unconditionally.
REQ-021 SHALL, in WB, write alu_result to R[rd] when rd!=0, giving an issue rate of one ALU instruction per 3 cycles.
REQ-022 SHALL hardwire R0 to 0: writes to R0 are dropped and reads of R0 return 0.
REQ-023 SHALL make register reads in EXEC observe any WB write from the preceding instruction, since it committed in an earlier cycle.
REQ-024 SHALL wrap arithmetic modulo 2^16; MUL keeps the low 16 bits of the product, as performed by the ALU.
REQ-025 SHALL ignore instr_valid held high outside IDLE, with no acceptance and no side effects.

Reset
REQ-026 SHALL, on rst low, force state=IDLE, R0–R7=0, halted=0, all ALU outputs=0 and the latched instruction=0 (NOP).
REQ-027 SHALL, on reset asserted in EXEC or WB, discard the in-flight instruction with no register write.
REQ-028 SHALL drive instr_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-029 SHALL, with DECODE_RETIRE_CNT_EN defined, add output retire_cnt, 16 bits: count of instructions retired (NOP at accept, ALU/MOVI at WB, HALT at accept), wrapping at 0xFFFF->0 and reset to 0.
REQ-030 SHALL, without DECODE_RETIRE_CNT_EN, have no retire_cnt port and no counter logic.

Structure
REQ-031 SHALL take opcode constants (NOP, ADD, ADDI, SUB, SUBI, MUL, MOVI, HALT), instruction field positions and FSM state encodings from a shared package cpu_pkg; the ALU uses the same opcode values.
REQ-032 SHALL place the 8x16 register file in sub-module regfile, with 2 asynchronous read ports, 1 debug read port and 1 synchronous write port.

Verification
REQ-033 SHALL verify reset then MOVI r1,#5: alu_opcode=010, alu_a=0, alu_imm=5 in EXEC; R1=5 after WB; instr_ready high again on cycle 3.
REQ-034 SHALL verify R1=5, R2=-3, then ADD r3,r1,r2 -> R3=2; SUB r4,r2,r1 -> R4=-8 (0xFFF8).
REQ-035 SHALL verify MOVI r1,#-64 then MUL r2,r1,#-64: imm sign-extends to 0xFFC0 and R2=4096; 0x7FFF ADDI 1 -> 0x8000 (wrap).
REQ-036 SHALL verify ADDI r0,r0,#7 -> R0 reads 0; NOP keeps instr_ready high and leaves registers unchanged.
REQ-037 SHALL verify HALT then instr_valid held high for 10 cycles -> halted=1, instr_ready=0, no register change; rst low -> IDLE.
REQ-038 SHALL verify rst asserted during WB of ADD r5 -> R5 stays 0; with DECODE_RETIRE_CNT_EN, 4 retired instructions give retire_cnt=4.
